dmem_bridge: RTL and testbench

Data-side memory bridge sitting directly downstream of the multi-cycle RV32 core's data port, between the core and the backing data SRAM/bus. It accepts word-granular load/store requests over a valid/ready handshake, posts stores into a small write buffer so the core does not wait for memory, and serialises loads behind outstanding stores to keep program order. The memory side is a single-outstanding valid/ready request channel with a separate read-return strobe, so variable-latency memories can be attached.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_wbuf.sv | 82 ++++++++
 rtl/dmem_bridge.sv | 150 +++++++++++++++
 tb/tb_dmem_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-side memory bridge: load FSM states and write-buffer entry layout.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_DRAIN = 2'd1,
    RD_REQ   = 2'd2,
    RD_WAIT  = 2'd3
  } state_e;

  localparam logic [3:0] WSTRB_LOAD = 4'h0;
  localparam logic [3:0] WSTRB_FULL = 4'hF;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/dmem_wbuf.sv
// Posted-store circular FIFO with wrap-bit pointers. With DMEM_WB_FWD_EN defined it also
// exposes a newest-entry address lookup used for store-to-load forwarding.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [29:0] push_waddr_i,
  input  logic [3:0]  push_wstrb_i,
  input  logic [31:0] push_wdata_i,
  input  logic        pop_i,
  output logic [29:0] head_waddr_o,
  output logic [3:0]  head_wstrb_o,
  output logic [31:0] head_wdata_o,
  output logic        empty_o,
  output logic        full_o,
  output logic        last_o
`ifdef DMEM_WB_FWD_EN
  ,
  input  logic [29:0] lkp_addr_i,
  output logic        lkp_hit_o,
  output logic [31:0] lkp_data_o
`endif
);

  localparam int AW = $clog2(WB_DEPTH);

  logic [AW:0] head_q, head_d, tail_q, tail_d, count;
  wb_entry_t   ent_q [WB_DEPTH];

  assign count   = tail_q - head_q;
  assign empty_o = (head_q == tail_q);
  assign full_o  = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
  assign last_o  = (count == (AW+1)'(1));

  assign head_waddr_o = ent_q[head_q[AW-1:0]].waddr;
  assign head_wstrb_o = ent_q[head_q[AW-1:0]].wstrb;
  assign head_wdata_o = ent_q[head_q[AW-1:0]].wdata;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_i)  head_d = head_q + (AW+1)'(1);
    if (push_i) tail_d = tail_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) ent_q[tail_q[AW-1:0]] <= '{waddr: push_waddr_i, wstrb: push_wstrb_i, wdata: push_wdata_i};
  end

`ifdef DMEM_WB_FWD_EN
  logic [AW-1:0] idx;

  // Walk oldest to newest so the last matching entry decides the result.
  always_comb begin
    lkp_hit_o  = 1'b0;
    lkp_data_o = '0;
    idx        = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = head_q[AW-1:0] + AW'(i);
      if (((AW+1)'(i) < count) && (ent_q[idx].waddr == lkp_addr_i)) begin
        lkp_hit_o  = (ent_q[idx].wstrb == WSTRB_FULL);
        lkp_data_o = ent_q[idx].wdata;
      end
    end
  end
`endif

endmodule

// File: rtl/dmem_bridge.sv
// Core data-port to memory bridge: posted stores via dmem_wbuf, loads ordered behind them.
// Define DMEM_WB_FWD_EN to answer loads from a full-word buffered store without a memory read.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [31:0] cpu_req_addr,
  input  logic [3:0]  cpu_req_wstrb,
  input  logic [31:0] cpu_req_wdata,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rsp_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [29:0] ld_addr_q, ld_addr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        wb_empty, wb_full, wb_last;
  logic [29:0] head_waddr;
  logic [3:0]  head_wstrb;
  logic [31:0] head_wdata;
  logic        accept, is_load, push, pop, drain_vld;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_req_addr[1:0];

  assign cpu_req_ready = !rst && (state_q == IDLE) && !wb_full;
  assign accept        = cpu_req_valid && cpu_req_ready;
  assign is_load       = (cpu_req_wstrb == WSTRB_LOAD);
  assign push          = accept && !is_load;
  // The buffer owns the memory channel except while the load itself is on it.
  assign drain_vld     = !wb_empty && ((state_q == IDLE) || (state_q == RD_DRAIN));
  assign pop           = !rst && drain_vld && mem_ready;

`ifdef DMEM_WB_FWD_EN
  logic        lkp_hit;
  logic [31:0] lkp_data;
`endif

  dmem_wbuf #(.WB_DEPTH(WB_DEPTH)) u_wbuf (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_waddr_i (cpu_req_addr[31:2]),
    .push_wstrb_i (cpu_req_wstrb),
    .push_wdata_i (cpu_req_wdata),
    .pop_i        (pop),
    .head_waddr_o (head_waddr),
    .head_wstrb_o (head_wstrb),
    .head_wdata_o (head_wdata),
    .empty_o      (wb_empty),
    .full_o       (wb_full),
    .last_o       (wb_last)
`ifdef DMEM_WB_FWD_EN
    ,
    .lkp_addr_i   (cpu_req_addr[31:2]),
    .lkp_hit_o    (lkp_hit),
    .lkp_data_o   (lkp_data)
`endif
  );

  always_comb begin
    state_d     = state_q;
    ld_addr_d   = ld_addr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_valid   = 1'b0;
    mem_addr    = '0;
    mem_wstrb   = '0;
    mem_wdata   = '0;

    if (drain_vld) begin
      mem_valid = 1'b1;
      mem_addr  = {head_waddr, 2'b00};
      mem_wstrb = head_wstrb;
      mem_wdata = head_wdata;
    end

    unique case (state_q)
      IDLE: begin
        if (accept && is_load) begin
          ld_addr_d = cpu_req_addr[31:2];
`ifdef DMEM_WB_FWD_EN
          if (lkp_hit) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = lkp_data;
          end else if (wb_empty) state_d = RD_REQ;
          else                   state_d = RD_DRAIN;
`else
          if (wb_empty) state_d = RD_REQ;
          else          state_d = RD_DRAIN;
`endif
        end
      end
      // Leave as soon as the final pop is committed so RD_REQ follows it directly.
      RD_DRAIN: if (wb_empty || (wb_last && pop)) state_d = RD_REQ;
      RD_REQ: begin
        mem_valid = 1'b1;
        mem_addr  = {ld_addr_q, 2'b00};
        mem_wstrb = WSTRB_LOAD;
        if (mem_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wstrb = '0;
      mem_wdata = '0;
    end
  end

  assign cpu_rsp_valid = !rst && rsp_valid_q;
  assign cpu_rsp_rdata = rst ? '0 : rsp_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
    ld_addr_q <= ld_addr_d;
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed timing steps plus randomized traffic against a
// program-order memory model; memory responder and monitor run inside tick().
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr = '0;
  logic [3:0]  cpu_req_wstrb = '0;
  logic [31:0] cpu_req_wdata = '0;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rsp_rdata;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_bridge #(.WB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr(cpu_req_addr), .cpu_req_wstrb(cpu_req_wstrb), .cpu_req_wdata(cpu_req_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } st_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mem_img [256];
  logic [31:0] shadow  [256];
  st_t         stq [$];
  logic [31:0] rspq [$];
  logic [31:0] ldq [$];
  int          rdy_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  int          inject = 0;
  bit          rd_pend = 0;
  int          rd_cnt = 0;
  logic [31:0] rd_data = '0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr, prev_data;
  logic [3:0]  prev_strb;
  bit          accepted = 0;
  int          first_pop_cyc = -1;
  int          last_acc_cyc = -1;
  int          rsp_seen = 0;
  int          saved;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge (what the next edge will capture), respond after the edge.
  task automatic tick();
    st_t e;
    bit  fwd;
    @(negedge clk);
    cyc++;
    accepted = 0;
    if (rst) begin
      check("rst_ready", 32'(cpu_req_ready), 32'd0);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
      stq.delete(); rspq.delete(); ldq.delete();
      shadow = mem_img;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(mem_valid), 32'd1);
        check("hold_addr", mem_addr, prev_addr);
        check("hold_strb", 32'(mem_wstrb), 32'(prev_strb));
        check("hold_data", mem_wdata, prev_data);
      end
      if (cpu_rsp_valid) begin
        rsp_seen++;
        if (rspq.size() == 0) check("unexp_rsp", 32'(cpu_rsp_valid), 32'd0);
        else check("rsp_data", cpu_rsp_rdata, rspq.pop_front());
      end
      if (cpu_req_valid && cpu_req_ready) begin
        accepted = 1;
        last_acc_cyc = cyc;
        if (cpu_req_wstrb != 4'h0) begin
          stq.push_back('{addr: {cpu_req_addr[31:2], 2'b00}, strb: cpu_req_wstrb, data: cpu_req_wdata});
          shadow[cpu_req_addr[9:2]] = merge(shadow[cpu_req_addr[9:2]], cpu_req_wdata, cpu_req_wstrb);
        end else begin
          fwd = 0;
`ifdef DMEM_WB_FWD_EN
          for (int i = stq.size() - 1; i >= 0; i--) begin
            if (stq[i].addr[31:2] == cpu_req_addr[31:2]) begin
              fwd = (stq[i].strb == 4'hF);
              break;
            end
          end
`endif
          rspq.push_back(shadow[cpu_req_addr[9:2]]);
          if (!fwd) ldq.push_back({cpu_req_addr[31:2], 2'b00});
        end
      end
      if (mem_valid && mem_ready) begin
        if (mem_wstrb != 4'h0) begin
          if (first_pop_cyc < 0) first_pop_cyc = cyc;
          if (stq.size() == 0) check("unexp_write", 32'(mem_valid), 32'd0);
          else begin
            e = stq.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_strb", 32'(mem_wstrb), 32'(e.strb));
            check("wr_data", mem_wdata, e.data);
            mem_img[mem_addr[9:2]] = merge(mem_img[mem_addr[9:2]], mem_wdata, mem_wstrb);
          end
        end else begin
          check("rd_order", 32'(stq.size()), 32'd0);
          if (ldq.size() == 0) check("unexp_read", 32'(mem_valid), 32'd0);
          else check("rd_addr", mem_addr, ldq.pop_front());
          rd_pend = 1;
          rd_cnt  = int'($urandom_range(lat_max, lat_min));
          rd_data = mem_img[mem_addr[9:2]];
        end
      end
      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      prev_strb  = mem_wstrb;
      prev_data  = mem_wdata;
    end
    @(posedge clk);
    #1;
    mem_ready  = ($urandom_range(99) < 32'(rdy_pct));
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom();
    if (rd_pend) begin
      rd_cnt--;
      if (rd_cnt <= 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_data;
        rd_pend    = 0;
      end
    end else if (inject > 0) begin
      mem_rvalid = 1'b1;
      inject--;
    end
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int n;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = a;
    cpu_req_wstrb = s;
    cpu_req_wdata = d;
    n = 0;
    tick();
    while (!accepted && n < 300) begin
      tick();
      n++;
    end
    check("req_accept_timeout", 32'(accepted), 32'd1);
    cpu_req_valid = 1'b0;
    cpu_req_wstrb = 4'h0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((stq.size() != 0 || rspq.size() != 0 || ldq.size() != 0 || rd_pend) && n < 2000) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(stq.size() + rspq.size() + ldq.size()), 32'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = $urandom();
    shadow = mem_img;

    repeat (3) tick();
    rst = 1'b0;
    #2;
    check("post_rst_ready", 32'(cpu_req_ready), 32'd1);
    check("post_rst_mem_valid", 32'(mem_valid), 32'd0);
    check("post_rst_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
    check("post_rst_mem_addr", mem_addr, 32'd0);

    // Posted store appears on the memory channel the cycle after accept.
    rdy_pct = 100;
    tick();
    req(32'h100, 4'hF, 32'hDEADBEEF);
    #2;
    check("st_mem_valid", 32'(mem_valid), 32'd1);
    check("st_mem_addr", mem_addr, 32'h100);
    check("st_mem_wstrb", 32'(mem_wstrb), 32'hF);
    check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("st_no_rsp", 32'(cpu_rsp_valid), 32'd0);
    wait_idle();

    // Fill the buffer with memory stalled; the fifth store waits for a pop.
    rdy_pct = 0;
    tick();
    for (int i = 0; i < 4; i++) req(32'h180 + 32'(i * 4), 4'hF, 32'hA0A0_0000 + 32'(i));
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h190;
    cpu_req_wstrb = 4'hF;
    cpu_req_wdata = 32'hA0A0_0004;
    repeat (3) begin
      tick();
      #2;
      check("full_stall_ready", 32'(cpu_req_ready), 32'd0);
      check("full_stall_acc", 32'(accepted), 32'd0);
    end
    first_pop_cyc = -1;
    rdy_pct = 100;
    for (int n = 0; n < 50 && !accepted; n++) tick();
    check("fifth_accepted", 32'(accepted), 32'd1);
    check("fifth_after_pop", 32'(last_acc_cyc - first_pop_cyc), 32'd1);
    cpu_req_valid = 1'b0;
    cpu_req_wstrb = 4'h0;
    wait_idle();

    // Load from an empty buffer with a ready memory: rsp three cycles after accept.
    lat_min = 1; lat_max = 1;
    req(32'h40, 4'h0, 32'h0);
    #2;
    check("ld_mem_valid", 32'(mem_valid), 32'd1);
    check("ld_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("ld_mem_addr", mem_addr, 32'h40);
    tick();
    #2;
    check("ld_rsp_early", 32'(cpu_rsp_valid), 32'd0);
    tick();
    #2;
    check("ld_rsp_t3", 32'(cpu_rsp_valid), 32'd1);
    check("ld_rsp_data", cpu_rsp_rdata, shadow[16]);
    wait_idle();

    // Load right behind a store to the same word must see the stored value.
    rdy_pct = 50; lat_max = 3;
    req(32'h200, 4'hF, 32'h11223344);
    req(32'h200, 4'h0, 32'h0);
    wait_idle();
    check("st_ld_data", cpu_rsp_rdata, 32'h11223344);

    // Full-word buffered store to 0x300, then load it while memory is stalled.
    rdy_pct = 0;
    tick();
    req(32'h300, 4'hF, 32'hCAFEF00D);
    req(32'h300, 4'h0, 32'h0);
    #2;
`ifdef DMEM_WB_FWD_EN
    check("fwd_rsp_valid", 32'(cpu_rsp_valid), 32'd1);
    check("fwd_rsp_data", cpu_rsp_rdata, 32'hCAFEF00D);
`else
    check("nofwd_rsp_valid", 32'(cpu_rsp_valid), 32'd0);
`endif
    check("fwd_no_read", 32'(mem_wstrb), 32'hF);
    rdy_pct = 100;
    wait_idle();

    // Partial store never forwards: load waits for drain plus memory read.
    rdy_pct = 0;
    tick();
    req(32'h300, 4'h3, 32'h12345678);
    req(32'h300, 4'h0, 32'h0);
    repeat (3) begin
      #2;
      check("part_no_rsp", 32'(cpu_rsp_valid), 32'd0);
      tick();
    end
    rdy_pct = 100;
    wait_idle();
    check("part_rsp_data", cpu_rsp_rdata, 32'hCAFE5678);

    // Stray read strobes while idle must be ignored.
    saved = rsp_seen;
    inject = 2;
    repeat (4) tick();
    check("spur_rvalid", 32'(rsp_seen - saved), 32'd0);

    // Reset while the read is outstanding; its late return must be dropped.
    lat_min = 4; lat_max = 4;
    saved = rsp_seen;
    req(32'h80, 4'h0, 32'h0);
    for (int n = 0; n < 50 && !rd_pend; n++) tick();
    check("rw_read_issued", 32'(rd_pend), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check("rw_ready", 32'(cpu_req_ready), 32'd1);
    check("rw_mem_valid", 32'(mem_valid), 32'd0);
    repeat (5) tick();
    #2;
    check("rw_no_rsp", 32'(rsp_seen - saved), 32'd0);
    check("rw_ready_after", 32'(cpu_req_ready), 32'd1);
    wait_idle();

    // Randomized mixed traffic.
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [3:0]  s;
      if ($urandom_range(9) == 0) rdy_pct = int'($urandom_range(100, 20));
      a = ($urandom_range(15) << 2) | $urandom_range(3);
      if ($urandom_range(99) < 35) s = 4'h0;
      else if ($urandom_range(1) == 1) s = 4'hF;
      else s = 4'($urandom_range(15, 1));
      req(a, s, $urandom());
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) tick();
    end
    rdy_pct = 100;
    wait_idle();
    for (int i = 0; i < 16; i++) check("mem_final", mem_img[i], shadow[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
